// File: rtl/addr_enc_arbiter_pkg.sv
// addr_enc_pkg: shared address width, arbiter FSM encodings and width helper
package addr_enc_pkg;

    localparam int ADDR_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_PAUSED = 2'd3
    } state_t;

    // Index width for n items; never narrower than one bit
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/addr_enc_arbiter_rr_pick.sv
// rr_pick: round-robin picker, first set request at or above ptr with wrap
module rr_pick
    import addr_enc_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    // Walk requesters starting at ptr; the first one found wins
    always_comb begin
        int j;
        j = 0;
        gnt = '0;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (gnt == '0 && req[j]) begin
                gnt[j] = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/addr_enc_arbiter.sv
// addr_enc_arbiter: round-robin sharing of one AddrEncoder with tagged response return.
// Optional per-requester grant counters when AE_ARB_PERF_EN is defined.
module addr_enc_arbiter
#(
    parameter int NREQ = 4,
    parameter int ADDR_W = addr_enc_pkg::ADDR_W,
    parameter int ENC_LAT = 1,
    localparam int IW = addr_enc_pkg::clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   pause,
    output logic [ADDR_W-1:0]      enc_in,
    input  logic [ADDR_W-1:0]      enc_out,
    output logic                   rsp_valid,
    output logic [IW-1:0]          rsp_id,
    output logic [ADDR_W-1:0]      rsp_data,
    output logic                   busy,
    output logic [1:0]             state_o
`ifdef AE_ARB_PERF_EN
    ,
    input  logic                   cnt_clr,
    output logic [NREQ*16-1:0]     grant_cnt
`endif
);

    import addr_enc_pkg::*;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt;
    logic [ENC_LAT:0] tag_v;
    logic [IW-1:0]   tag_id [ENC_LAT+1];
    logic            grant_en;
    logic            accept;

    rr_pick #(.N(NREQ)) u_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign grant_en  = (state == ST_IDLE || state == ST_ISSUE) && !pause;
    assign req_ready = grant_en ? gnt : '0;
    assign accept    = |req_ready;
    assign busy      = |tag_v || rsp_valid;
    assign state_o   = state;

    // Arbiter FSM, round-robin pointer and encoder input register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            enc_in <= '0;
        end else begin
            if (accept) begin
                enc_in <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
                ptr    <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
            end
            case (state)
                ST_IDLE:   if (pause) state <= ST_DRAIN; else if (|req_valid) state <= ST_ISSUE;
                ST_ISSUE:  if (pause) state <= ST_DRAIN; else if (req_valid == '0) state <= ST_IDLE;
                ST_DRAIN:  if (tag_v == '0) state <= ST_PAUSED;
                ST_PAUSED: if (!pause) state <= ST_IDLE;
            endcase
        end
    end

    // Tag pipeline tracks each accept through the encoder; exit stage registers the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v     <= '0;
            for (int i = 0; i <= ENC_LAT; i++) tag_id[i] <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            tag_v     <= {tag_v[ENC_LAT-1:0], accept};
            tag_id[0] <= gnt_idx;
            for (int i = 1; i <= ENC_LAT; i++) tag_id[i] <= tag_id[i-1];
            rsp_valid <= tag_v[ENC_LAT];
            if (tag_v[ENC_LAT]) begin
                rsp_id   <= tag_id[ENC_LAT];
                rsp_data <= enc_out;
            end
        end
    end

`ifdef AE_ARB_PERF_EN
    // Saturating per-requester accept counters; clear wins over a coincident accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (cnt_clr) grant_cnt[i*16 +: 16] <= '0;
                else if (req_ready[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/addr_enc_arbiter.md
Name: addr_enc_arbiter

Overview:
- Shares one 12-bit AddrEncoder instance among NREQ requesters using round-robin arbitration.
- Drives the encoder's input register and tracks in-flight requests through the encoder's fixed latency with a tag pipeline.
- Returns each result to the requester that issued it.
- Provides a pause/drain control for quiescing the encoder, e.g. before reconfiguration or scan.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDR_W, 12, address/encoded width; must match AddrEncoder.
- ENC_LAT, 1, clock edges from encoder `in` change to valid `out` (1..4).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request.
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_ready  out  NREQ  one-hot grant, combinational.
- pause  in  1  stop issuing and drain.
- enc_in  out  ADDR_W  to AddrEncoder `in`, registered.
- enc_out  in  ADDR_W  from AddrEncoder `out`.
- rsp_valid  out  1  result pulse.
- rsp_id  out  clog2(NREQ)  requester index of the result.
- rsp_data  out  ADDR_W  encoded result.
- busy  out  1  any request in flight.
- state_o  out  2  FSM state, debug.

Behaviour:
- Reset, async on rst_n low:
  - State is IDLE; the round-robin pointer is 0.
  - enc_in, rsp_data and rsp_id are 0; rsp_valid and busy are 0.
  - The tag pipeline is cleared, so in-flight work is discarded; no rsp_valid is produced for it after reset releases.
- FSM states: IDLE=0, ISSUE=1, DRAIN=2, PAUSED=3.
  - IDLE to ISSUE when any req_valid is high and pause is low.
  - ISSUE to IDLE when no req_valid is high.
  - Any of IDLE or ISSUE to DRAIN when pause is high.
  - DRAIN to PAUSED when the tag pipeline is empty.
  - PAUSED to IDLE when pause is low.
  - If pause drops during DRAIN, drain still completes before leaving DRAIN.
- Grant:
  - In IDLE or ISSUE with pause low, req_ready is the one-hot first requester with req_valid set, searching from the pointer upward with wrap.
  - Otherwise req_ready is 0.
  - Accept means req_valid[g] and req_ready[g] both high at a rising edge.
  - At the accept edge: enc_in takes req_addr[g], and the pointer becomes (g+1) mod NREQ.
  - With no accept, enc_in holds its value and the pointer holds.
- Throughput: one accept per cycle, back-to-back, with no bubbles.
- Tag pipeline:
  - Depth ENC_LAT+1; each entry is {valid, id}.
  - rsp_data and rsp_id are registered from enc_out and the tag at the pipeline exit.
  - Required timing: for an accept at edge k, rsp_valid is high for exactly one cycle after edge k+ENC_LAT+1, with rsp_data equal to the encoder result of that address.
- Response path has no backpressure; consumers must sink every pulse.
- busy is high when any tag pipeline entry or rsp_valid is high.
- req_valid dropping before an accept is legal; no grant is recorded for it.
- A single active requester is granted every cycle, and the pointer still advances.
- pause rising in the same cycle as a pending request: no grant is issued in that cycle.

Optional Feature:
- Macro AE_ARB_PERF_EN.
- When defined:
  - Add output grant_cnt, NREQ*16 bits: per-requester saturating 16-bit accept counters, reset to 0 and holding at 16'hFFFF.
  - Add input cnt_clr, 1 bit, a synchronous clear of all counters.
  - If cnt_clr and an accept coincide, the counter becomes 0.
- When undefined: neither port exists and there are no counters; behaviour is otherwise identical.

Decomposition:
- Package addr_enc_pkg holds:
  - ADDR_W=12;
  - the state encodings ST_IDLE, ST_ISSUE, ST_DRAIN, ST_PAUSED;
  - the function clog2 used for the rsp_id width.
- One sub-module, rr_pick (parameter N), maps req[N] and ptr to a one-hot gnt[N] and a binary gnt_idx, purely combinationally.
- The top level instantiates rr_pick, the FSM, the tag pipeline and the output registers; the AddrEncoder itself stays outside, wired in by the parent or bench.

Test Plan:
- Reset then single request: req_valid=4'b0001 with addr 12'h0A5 for 1 cycle, ENC_LAT=1 → one rsp_valid 2 cycles after accept, rsp_id=0, rsp_data equal to the model's encoding of 12'h0A5; busy returns to 0 the next cycle.
- Full contention: req_valid=4'b1111 held for 8 cycles → grant order 0,1,2,3,0,1,2,3; 8 responses back-to-back with matching ids; no gaps.
- Pointer wrap/skip: pointer=3 after a grant to 2, then req_valid=4'b0101 → grant 0 then 2; next with only 2 requesting → 2 is granted every cycle.
- Pause drain: 3 accepts in flight, assert pause → req_ready=0 immediately; state_o is 2 until the last rsp_valid, then 3; deassert pause → state_o=0; the next request is accepted.
- Reset mid-flight: 2 accepts, assert rst_n=0 asynchronously between edges → all outputs are 0 at once; after release, no stale rsp_valid appears within 5 cycles.
- With AE_ARB_PERF_EN defined:
  - 70000 accepts to requester 1 → grant_cnt[1] is 16'hFFFF.
  - cnt_clr pulse → all counters are 0.
